// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter in front of a 2-to-4 decoder select bus.
//
// A winner keeps its grant for as long as it keeps its request asserted. Fairness comes
// from a rotating priority pointer that moves just past the last owner whenever a grant is
// released. Every handover passes through at least one cycle with gnt = 0, so the decoder
// select never switches directly from one owner to another.
//
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX consecutive
// cycles. A revoke pulses `to` for one cycle. Without the macro, grants are held
// indefinitely and `to` stays 0.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles before a forced revoke (2..255). It is only
//             used when ARB_TIMEOUT_EN is defined.
// Ports:
//   clk   in   clock; every state update happens on the rising edge
//   rst   in   synchronous active-high reset
//   e     in   enable; when it is low, no grant is issued and any held grant is dropped
//   req   in   [3:0] request vector; bit n belongs to requester n
//   gnt   out  [3:0] registered one-hot grant; 0 when no grant is held
//   gidx  out  [1:0] registered index of the owner; it holds its last value while idle
//   busy  out  high while a grant is held; this is the decoder enable
//   to    out  one-cycle pulse after a timeout revoke

module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gidx,
  output logic       busy,
  output logic       to
);

`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gidx_q, gidx_d;
  logic       to_q, to_d;

  logic [1:0] win_idx;
  logic       hold_expired;

  // Scan from ptr+3 down to ptr+0. The lowest offset from ptr that has a request wins.
  always_comb begin
    win_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  // This is constant 0 unless the timeout feature is compiled in.
  assign hold_expired = TimeoutEn && (cnt_q == HoldLast);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d = 4'b0000;
        if (e && (req != 4'b0000)) begin
          gidx_d  = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          cnt_d   = 8'd0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!e) begin
          // Disable wins over release and timeout, and it leaves the pointer alone.
          gnt_d   = 4'b0000;
          state_d = StIdle;
        end else if (!req[gidx_q]) begin
          gnt_d   = 4'b0000;
          ptr_d   = gidx_q + 2'd1;
          state_d = StIdle;
        end else if (hold_expired) begin
          gnt_d   = 4'b0000;
          ptr_d   = gidx_q + 2'd1;
          to_d    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      gidx_q  <= 2'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      to_q    <= to_d;
    end
  end

  assign gnt  = gnt_q;
  assign gidx = gidx_q;
  assign busy = |gnt_q;
  assign to   = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4. The driver applies directed and random stimulus. After each
// rising edge, a behavioural model (an owner number, a priority pointer and a held-cycle
// count) predicts the registered outputs and queues the prediction. A separate monitor
// compares the DUT outputs against the queue shortly after each edge.

module tb_rr_arbiter_4;

  localparam int unsigned HoldMax = 4;

`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic       busy;
  logic       to;

  always #5 clk = ~clk;

  rr_arbiter_4 #(
    .HOLD_MAX(HoldMax)
  ) dut (
    .clk (clk),
    .rst (rst),
    .e   (e),
    .req (req),
    .gnt (gnt),
    .gidx(gidx),
    .busy(busy),
    .to  (to)
  );

  // The expected value is packed as {gnt, gidx, busy, to}.
  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b0;

  // The model works in terms of owners: -1 means nobody holds the resource.
  int m_owner = -1;
  int m_ptr = 0;
  int m_gidx = 0;
  int m_held = 0;
  bit m_to = 1'b0;

  task automatic model_step();
    logic [3:0] g;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_gidx  = 0;
      m_held  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (e && req != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
          end
          m_gidx = m_owner;
          m_held = 1;
        end
      end else if (!e) begin
        m_owner = -1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (TimeoutEn && m_held == HoldMax) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    exp_q.push_back({g, 2'(m_gidx), (m_owner >= 0), m_to});
  endtask

  task automatic cycle(input logic r, input logic en, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    e   = en;
    req = rq;
    @(posedge clk);
    model_step();
    running = 1'b1;
  endtask

  // The monitor checks every cycle once stimulus has started.
  initial begin
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: output seen at %0t but no expected value queued", $time);
        end else begin
          exp = exp_q.pop_front();
          if ({gnt, gidx, busy, to} !== exp) begin
            miscompares++;
            $display("FAIL outputs @%0t: got gnt=%b gidx=%0d busy=%b to=%b, want gnt=%b gidx=%0d busy=%b to=%b",
                     $time, gnt, gidx, busy, to, exp[7:4], exp[3:2], exp[1], exp[0]);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] w_mask;
    // Reset with every request pending, then release it.
    cycle(1'b1, 1'b1, 4'b1111);
    cycle(1'b1, 1'b1, 4'b1111);
    // Round robin: each owner holds for two cycles, then drops its bit for one cycle.
    for (int w = 0; w < 4; w++) begin
      w_mask = 4'b0001 << w;
      cycle(1'b0, 1'b1, 4'b1111);
      cycle(1'b0, 1'b1, 4'b1111);
      cycle(1'b0, 1'b1, 4'b1111 & ~w_mask);
    end
    // The pointer wraps from 3 to 0.
    cycle(1'b0, 1'b1, 4'b1001);
    cycle(1'b0, 1'b1, 4'b1001);
    cycle(1'b0, 1'b1, 4'b1000);
    // Test enable precedence, then reset in the middle of a grant.
    cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b0, 1'b0, 4'b0100);
    cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b1, 1'b1, 4'b0100);
    cycle(1'b0, 1'b1, 4'b1111);
    cycle(1'b0, 1'b1, 4'b0000);
    // Hold two requests for a long time. This revokes in timeout builds and holds otherwise.
    cycle(1'b1, 1'b1, 4'b0011);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 4'b0011);
    // Random phase with sticky requests, so that holds last for several cycles.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rq = 4'($urandom_range(15));
      cycle(($urandom_range(63) == 0), ($urandom_range(7) != 0), rq);
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected values never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
